// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//   Fades three LED duty cycles (R, G, B) one LSB at a time toward latched
//   targets, one step every STEP_CLK_COUNT enabled clocks, and signals
//   completion with a single-cycle pulse.
//
// Parameters
//   N              duty-cycle resolution in bits
//   STEP_CLK_COUNT clocks per fade step (>= 1)
//
// Ports
//   clkIn                 clock, rising edge
//   rstIn                 synchronous active-high reset, highest priority
//   enIn                  global enable; low holds all state, doneOut forced 0
//   startIn               single-cycle fade request (retargets when busy)
//   snapIn                (RGB_FADE_SNAP_EN only) load targets straight into duties
//   targetRIn/GIn/BIn     per-channel target duty cycles
//   ledR/G/BDutyCycleOut  registered duty cycles to the LED controller
//   busyOut               registered, high while fading
//   doneOut               registered, one-cycle pulse on fade completion
//
// Optional feature: define RGB_FADE_SNAP_EN to add snapIn and the snap path.

module rgb_fade_sequencer #(
  parameter int N              = 8,
  parameter int STEP_CLK_COUNT = 20000
) (
  input  logic         clkIn,
  input  logic         rstIn,
  input  logic         enIn,
  input  logic         startIn,
`ifdef RGB_FADE_SNAP_EN
  input  logic         snapIn,
`endif
  input  logic [N-1:0] targetRIn,
  input  logic [N-1:0] targetGIn,
  input  logic [N-1:0] targetBIn,
  output logic [N-1:0] ledRDutyCycleOut,
  output logic [N-1:0] ledGDutyCycleOut,
  output logic [N-1:0] ledBDutyCycleOut,
  output logic         busyOut,
  output logic         doneOut
);

  // A single-clock step still needs a 1-bit counter that is always at its last value.
  localparam int CW = (STEP_CLK_COUNT > 1) ? $clog2(STEP_CLK_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CLK_COUNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;

  // Index 0 = R, 1 = G, 2 = B.
  logic [2:0][N-1:0]   r_duty;
  logic [2:0][N-1:0]   r_tgt;
  logic [2:0][N-1:0]   w_duty_nxt;
  logic [2:0][N-1:0]   w_tgt_nxt;
  logic [2:0][N-1:0]   w_tgt_in;
  logic [2:0][N-1:0]   w_duty_step;

  logic                r_busy;
  logic                r_done;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  logic                w_wrap;
  logic                w_at_tgt;

  // Move one LSB toward the target; equal channels hold, so no overshoot
  // and no wrap past 0 or 2^N-1 is possible.
  function automatic logic [N-1:0] step_toward(input logic [N-1:0] cur,
                                               input logic [N-1:0] tgt);
    logic [N-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 1'b1;
    end else if (cur > tgt) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  assign w_tgt_in = {targetBIn, targetGIn, targetRIn};
  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_at_tgt = (r_duty == r_tgt);

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_duty_step[i] = step_toward(r_duty[i], r_tgt[i]);
    end
  end

  // Next-state and next-data logic. Priority: (snap) > start > fade progress.
  // Starting on a completion edge takes the start branch, so the retarget
  // suppresses that doneOut.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_duty_nxt  = r_duty;
    w_tgt_nxt   = r_tgt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (enIn) begin
`ifdef RGB_FADE_SNAP_EN
      if (snapIn) begin
        w_duty_nxt  = w_tgt_in;
        w_tgt_nxt   = w_tgt_in;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end else
`endif
      if (startIn) begin
        w_tgt_nxt   = w_tgt_in;
        w_cnt_nxt   = '0;
        w_state_nxt = FADE;
        w_busy_nxt  = 1'b1;
      end else if (r_state == FADE) begin
        if (w_at_tgt) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
          if (w_wrap) begin
            w_duty_nxt = w_duty_step;
          end
        end
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_tgt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_duty <= w_duty_nxt;
      r_tgt  <= w_tgt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign ledRDutyCycleOut = r_duty[0];
  assign ledGDutyCycleOut = r_duty[1];
  assign ledBDutyCycleOut = r_duty[2];
  assign busyOut          = r_busy;
  assign doneOut          = r_done;

endmodule
